// File: rtl/packet_router.sv
// Routes words from the show-ahead RX FIFO to one of NUM_DEST valid/ready sinks, selected by packet command.
// Optional discarded-word counter on o_drop_count when PACKET_ROUTER_DROP_CNT_EN is defined.
module packet_router #(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 2,
  parameter int NUM_DEST   = 3,
  parameter int CNT_WIDTH  = 16,
  parameter int RESET_CMD  = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [CMD_WIDTH-1:0]  i_packet_command,
  input  logic                  i_packet_start_decode,
  input  logic                  i_packet_fully_decoded,
  output logic                  o_rx_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rx_fifo_data,
  input  logic                  i_rx_fifo_empty,
  output logic [DATA_WIDTH-1:0] o_dest_data,
  output logic [NUM_DEST-1:0]   o_dest_valid,
  input  logic [NUM_DEST-1:0]   i_dest_ready,
  output logic [1:0]            o_route_state,
  output logic [CNT_WIDTH-1:0]  o_word_count,
  output logic                  o_packet_done,
  output logic [15:0]           o_drop_count
);

  typedef enum logic [1:0] {
    ST_SWITCH  = 2'd0,
    ST_ROUTE   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam logic   RESET_MAPPED = (RESET_CMD >= 1) && (RESET_CMD <= NUM_DEST);
  localparam state_t RESET_STATE  = RESET_MAPPED ? ST_ROUTE : ST_DISCARD;
  localparam logic [CMD_WIDTH-1:0] RESET_ROUTE = CMD_WIDTH'(RESET_CMD);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  function automatic logic is_mapped(input logic [CMD_WIDTH-1:0] cmd);
    return (int'(cmd) >= 1) && (int'(cmd) <= NUM_DEST);
  endfunction

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [CMD_WIDTH-1:0] cmd);
    logic [NUM_DEST-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_DEST; k++)
      if (int'(cmd) == k + 1) oh[k] = 1'b1;
    return oh;
  endfunction

  state_t               state, state_nxt;
  logic [CMD_WIDTH-1:0] route, pend_cmd;
  logic                 pend, done_pend;
  logic                 held, accept, switch_go, pop;

  assign held      = |o_dest_valid;
  assign accept    = |(o_dest_valid & i_dest_ready);
  // A pending command takes effect only once the output register is free, so a held word never changes sink.
  assign switch_go = pend & (~held | accept) & (state != ST_SWITCH);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_ROUTE: begin
        pop = ~i_rx_fifo_empty & (~held | accept) & ~pend;
        if (switch_go) state_nxt = ST_SWITCH;
      end
      ST_DISCARD: begin
        pop = ~i_rx_fifo_empty & ~pend;
        if (switch_go) state_nxt = ST_SWITCH;
      end
      ST_SWITCH: state_nxt = is_mapped(route) ? ST_ROUTE : ST_DISCARD;
      default:   state_nxt = RESET_STATE;
    endcase
  end

  assign o_rx_fifo_rd_en = pop & ~i_reset;
  assign o_route_state   = state;
  assign o_packet_done   = done_pend & i_rx_fifo_empty & ~held & ~pend;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= RESET_STATE;
      route     <= RESET_ROUTE;
      pend      <= 1'b0;
      pend_cmd  <= '0;
      done_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (switch_go) route <= pend_cmd;
      if (i_packet_start_decode) begin
        pend     <= 1'b1;
        pend_cmd <= i_packet_command;
      end else if (switch_go) begin
        pend <= 1'b0;
      end
      if (i_packet_fully_decoded)                      done_pend <= 1'b1;
      else if (i_packet_start_decode || o_packet_done) done_pend <= 1'b0;
    end
  end

  // Output register stage: one word held for the current sink until accepted.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_dest_data  <= '0;
      o_dest_valid <= '0;
    end else if (pop && state == ST_ROUTE) begin
      o_dest_data  <= i_rx_fifo_data;
      o_dest_valid <= dest_onehot(route);
    end else if (accept) begin
      o_dest_valid <= '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                          o_word_count <= '0;
    else if (i_packet_start_decode)       o_word_count <= '0;
    else if (pop && !(&o_word_count))     o_word_count <= o_word_count + CNT_ONE;
  end

`ifdef PACKET_ROUTER_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                                          drop_cnt <= '0;
    else if (pop && state == ST_DISCARD && !(&drop_cnt))  drop_cnt <= drop_cnt + 16'd1;
  end

  assign o_drop_count = drop_cnt;
`else
  assign o_drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_packet_router.sv
// Directed bench for packet_router: FIFO model, routing, backpressure, switching, discard, done pulse, reset.
module tb_packet_router;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic        start_dec, fully_dec;
  logic        rd_en;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic [31:0] dest_data;
  logic [2:0]  dest_valid, dest_ready;
  logic [1:0]  route_state;
  logic [15:0] word_count, drop_count;
  logic        pkt_done;

  int n_pass = 0, n_total = 0, done_cnt = 0;
  logic last_rd, last_done;
  logic [31:0] fifo_q[$];
  logic [31:0] drop_w;

  always #5 clk = ~clk;

  packet_router dut (
    .i_clock(clk), .i_reset(rst), .i_packet_command(cmd), .i_packet_start_decode(start_dec),
    .i_packet_fully_decoded(fully_dec), .o_rx_fifo_rd_en(rd_en), .i_rx_fifo_data(fifo_data),
    .i_rx_fifo_empty(fifo_empty), .o_dest_data(dest_data), .o_dest_valid(dest_valid),
    .i_dest_ready(dest_ready), .o_route_state(route_state), .o_word_count(word_count),
    .o_packet_done(pkt_done), .o_drop_count(drop_count)
  );

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // Combinational outputs are sampled on the falling edge; the FIFO pops just after the rising edge.
  task automatic step();
    logic rd;
    @(negedge clk);
    rd        = rd_en;
    last_rd   = rd;
    last_done = pkt_done;
    if (pkt_done) done_cnt++;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) drop_w = fifo_q.pop_front();
    refresh();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; cmd = 2'd0; start_dec = 1'b0; fully_dec = 1'b0; dest_ready = 3'b000;
    refresh();
    step(); step();
    check("rst_valid", 64'(dest_valid), 64'h0);
    check("rst_data",  64'(dest_data),  64'h0);
    check("rst_count", 64'(word_count), 64'h0);
    check("rst_state", 64'(route_state), 64'h1);
    check("rst_done",  64'(pkt_done),   64'h0);
    check("rst_drop",  64'(drop_count), 64'h0);
    rst = 1'b0;
    step();

    // 1: single word to sink 0
    dest_ready = 3'b001;
    push(32'hDEADBEEF);
    step();
    check("t1_rd",    64'(last_rd),    64'h1);
    check("t1_valid", 64'(dest_valid), 64'h1);
    check("t1_data",  64'(dest_data),  64'hDEADBEEF);
    check("t1_count", 64'(word_count), 64'h1);
    step();
    check("t1_rd_once", 64'(last_rd),    64'h0);
    check("t1_clear",   64'(dest_valid), 64'h0);

    // 2: backpressure then streaming
    dest_ready = 3'b000;
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
    step();
    check("t2_rd0",   64'(last_rd),   64'h1);
    check("t2_data0", 64'(dest_data), 64'hA000_0000);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2_stall_rd",   64'(last_rd),    64'h0);
      check("t2_stall_data", 64'(dest_data),  64'hA000_0000);
      check("t2_stall_vld",  64'(dest_valid), 64'h1);
    end
    dest_ready = 3'b001;
    for (int i = 1; i < 4; i++) begin
      step();
      check("t2_stream_rd",   64'(last_rd),   64'h1);
      check("t2_stream_data", 64'(dest_data), 64'(32'hA000_0000 + 32'(i)));
    end
    step();
    check("t2_idle_rd", 64'(last_rd),    64'h0);
    check("t2_idle_v",  64'(dest_valid), 64'h0);
    check("t2_count",   64'(word_count), 64'h5);

    // 3: command change while a word is held
    dest_ready = 3'b000;
    push(32'hB000_0000); push(32'hB000_0001);
    step();
    check("t3_data0", 64'(dest_data),  64'hB000_0000);
    check("t3_cnt0",  64'(word_count), 64'h6);
    start_dec = 1'b1; cmd = 2'd2;
    step();
    start_dec = 1'b0;
    check("t3_nopop",  64'(last_rd),     64'h0);
    check("t3_hold",   64'(dest_valid),  64'h1);
    check("t3_clrcnt", 64'(word_count),  64'h0);
    check("t3_route",  64'(route_state), 64'h1);
    step();
    check("t3_pend_rd", 64'(last_rd), 64'h0);
    dest_ready = 3'b001;
    step();
    check("t3_acc_rd", 64'(last_rd),     64'h0);
    check("t3_acc_v",  64'(dest_valid),  64'h0);
    check("t3_switch", 64'(route_state), 64'h0);
    step();
    check("t3_sw_rd",  64'(last_rd),     64'h0);
    check("t3_back",   64'(route_state), 64'h1);
    dest_ready = 3'b010;
    step();
    check("t3_rd1",    64'(last_rd),    64'h1);
    check("t3_valid1", 64'(dest_valid), 64'h2);
    check("t3_data1",  64'(dest_data),  64'hB000_0001);
    check("t3_cnt1",   64'(word_count), 64'h1);
    step();
    check("t3_done_v", 64'(dest_valid), 64'h0);

    // 4: discard of unmapped command 0
    start_dec = 1'b1; cmd = 2'd0;
    step();
    start_dec = 1'b0;
    check("t4_clr", 64'(word_count), 64'h0);
    step();
    check("t4_switch", 64'(route_state), 64'h0);
    step();
    check("t4_discard", 64'(route_state), 64'h2);
    for (int i = 0; i < 5; i++) push(32'hC000_0000 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_rd",    64'(last_rd),    64'h1);
      check("t4_valid", 64'(dest_valid), 64'h0);
    end
    check("t4_count", 64'(word_count), 64'h5);
`ifdef PACKET_ROUTER_DROP_CNT_EN
    check("t4_drop", 64'(drop_count), 64'h5);
`else
    check("t4_drop", 64'(drop_count), 64'h0);
`endif
    step();
    check("t4_empty_rd", 64'(last_rd), 64'h0);

    // 5: packet done pulse
    start_dec = 1'b1; cmd = 2'd1;
    step();
    start_dec = 1'b0;
    step(); step();
    check("t5_route", 64'(route_state), 64'h1);
    dest_ready = 3'b001;
    push(32'hD000_0000); push(32'hD000_0001);
    fully_dec = 1'b1;
    done_cnt = 0;
    step();
    fully_dec = 1'b0;
    check("t5_data0", 64'(dest_data), 64'hD000_0000);
    step();
    check("t5_data1", 64'(dest_data), 64'hD000_0001);
    step();
    check("t5_early",  64'(last_done),  64'h0);
    check("t5_drain",  64'(dest_valid), 64'h0);
    step();
    check("t5_pulse", 64'(last_done), 64'h1);
    step(); step();
    check("t5_once",  64'(done_cnt),   64'h1);
    check("t5_count", 64'(word_count), 64'h2);

    // 6: asynchronous reset while a word is held
    dest_ready = 3'b000;
    push(32'hE000_0000);
    step();
    check("t6_held", 64'(dest_valid), 64'h1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_v", 64'(dest_valid), 64'h0);
    check("t6_async_d", 64'(dest_data),  64'h0);
    check("t6_async_c", 64'(word_count), 64'h0);
    push(32'hF000_0000);
    #1;
    check("t6_rst_nopop", 64'(rd_en), 64'h0);
    step();
    rst = 1'b0; dest_ready = 3'b001;
    check("t6_state", 64'(route_state), 64'h1);
    step();
    check("t6_rd",    64'(last_rd),    64'h1);
    check("t6_valid", 64'(dest_valid), 64'h1);
    check("t6_data",  64'(dest_data),  64'hF000_0000);
    check("t6_count", 64'(word_count), 64'h1);
    step();

    // 7: route to sink 2, then reset restores the default route
    start_dec = 1'b1; cmd = 2'd3;
    step();
    start_dec = 1'b0;
    step(); step();
    dest_ready = 3'b100;
    push(32'h6000_0000);
    step();
    check("t7_valid", 64'(dest_valid), 64'h4);
    check("t7_data",  64'(dest_data),  64'h6000_0000);
    dest_ready = 3'b000;
    push(32'h6000_0001);
    step();
    check("t7_stall", 64'(last_rd), 64'h0);
    #1 rst = 1'b1;
    #1;
    check("t7_async_v", 64'(dest_valid), 64'h0);
    step();
    rst = 1'b0; dest_ready = 3'b001;
    step();
    check("t7_rd",    64'(last_rd),    64'h1);
    check("t7_valid", 64'(dest_valid), 64'h1);
    check("t7_data",  64'(dest_data),  64'h6000_0001);
    check("t7_drop",  64'(drop_count), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
